run_index_tracker: RTL and testbench

Run-mode bookkeeping stage that sits directly upstream of the remainder-subtract accumulator in the JPEG-LS run path. Per run-mode pixel, it maintains RUNindex, the J[RUNindex] lookup, the running run_counter, and the next segment threshold run_counter_compare. It also registers the accumulated subtract value fed back from the downstream stage. It emits segment-complete ('1' bit) pulses and interruption/end-of-line events with the remainder value and bit count for the run coder.

---
 rtl/run_index_tracker_pkg.sv | 31 +++
 rtl/run_index_tracker_j_table_rom.sv | 12 +
 rtl/run_index_tracker.sv | 181 ++++++++++++++++++
 tb/tb_run_index_tracker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_index_tracker_pkg.sv
// run_index_tracker shared definitions
// mode codes, run states and the J table
package run_index_tracker_pkg;

  localparam int INDEX_LENGTH = 5;

  typedef enum logic [1:0] {
    MODE_REGULAR = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_INTR    = 2'd2,
    MODE_EOL     = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // entry 31 is the leftmost nibble
  localparam logic [31:0][3:0] J_TABLE = {
    4'd15, 4'd14, 4'd13, 4'd12,
    4'd11, 4'd10, 4'd9,  4'd8,
    4'd7,  4'd7,  4'd6,  4'd6,
    4'd5,  4'd5,  4'd4,  4'd4,
    4'd3,  4'd3,  4'd3,  4'd3,
    4'd2,  4'd2,  4'd2,  4'd2,
    4'd1,  4'd1,  4'd1,  4'd1,
    4'd0,  4'd0,  4'd0,  4'd0
  };

endpackage

// File: rtl/run_index_tracker_j_table_rom.sv
// j_table_rom: RUNindex -> J lookup
// purely combinational, shared with the run decoder
module j_table_rom
  import run_index_tracker_pkg::*;
(
  input  logic [INDEX_LENGTH-1:0] index,
  output logic [3:0]              j
);

  assign j = J_TABLE[index];

endmodule

// File: rtl/run_index_tracker.sv
// run_index_tracker: JPEG-LS run-mode bookkeeping
// RUNindex, run counters, segment and run-end events
module run_index_tracker
  import run_index_tracker_pkg::*;
#(
  parameter int J_length        = 4,
  parameter int runcount_length = 16,
  parameter int mode_length     = 2,
  parameter int index_length    = INDEX_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [mode_length-1:0]     mode,
  input  logic [runcount_length-1:0] remainder_subtract,
  output logic [mode_length-1:0]     previous_mode,
  output logic [runcount_length-1:0] run_counter,
  output logic [runcount_length-1:0] run_counter_compare,
  output logic [runcount_length-1:0] remainder_subtract_accum,
  output logic [index_length-1:0]    run_index,
  output logic [J_length-1:0]        J,
  output logic                       seg_done,
  output logic                       run_end,
  output logic [runcount_length-1:0] run_remainder,
  output logic [J_length-1:0]        remainder_bits,
  output logic                       eol_flush
);

  localparam logic [runcount_length-1:0] CNT_MAX = '1;

  function automatic logic [runcount_length-1:0] pow2(
    input logic [3:0] e
  );
    return runcount_length'(1) << e;
  endfunction

  state_e state_q, state_d;
  logic [runcount_length-1:0] cnt_q, cnt_d;
  logic [runcount_length-1:0] cmp_q, cmp_d;
  logic [runcount_length-1:0] acc_q, acc_d;
  logic [runcount_length-1:0] rrem_q, rrem_d;
  logic [index_length-1:0] idx_q, idx_d;
  logic [index_length-1:0] idx_inc, idx_dec;
  logic [mode_length-1:0] prev_q, prev_d;
  logic [J_length-1:0] rbits_q, rbits_d;
  logic cmp_sat_q, cmp_sat_d;
  logic seg_q, seg_d;
  logic rend_q, rend_d;
  logic eol_q, eol_d;

  logic [3:0] j_cur, j_inc, j_dec;
  logic [runcount_length-1:0] cnt_inc, cmp_add;
  logic cmp_carry, seg_hit;
  logic is_run, is_intr, is_eol;
  logic is_count, is_close;

  assign idx_inc = (idx_q == '1) ? idx_q
                 : idx_q + index_length'(1);
  assign idx_dec = (idx_q == '0) ? idx_q
                 : idx_q - index_length'(1);

  j_table_rom u_j_cur (.index(idx_q),   .j(j_cur));
  j_table_rom u_j_inc (.index(idx_inc), .j(j_inc));
  j_table_rom u_j_dec (.index(idx_dec), .j(j_dec));

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q
                 : cnt_q + runcount_length'(1);

  // a saturated threshold is unreachable
  assign seg_hit = !cmp_sat_q && (cnt_inc == cmp_q);

  assign {cmp_carry, cmp_add} =
    {1'b0, cmp_q} + {1'b0, pow2(j_inc)};

  assign is_run  = mode == mode_length'(MODE_RUN);
  assign is_intr = mode == mode_length'(MODE_INTR);
  assign is_eol  = mode == mode_length'(MODE_EOL);

  assign is_count = in_valid && (is_run || is_eol);
  assign is_close = in_valid && is_intr
                 && (state_q == S_RUN);

  // next-state and event decode for one pixel
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    cmp_sat_d = cmp_sat_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    prev_d    = prev_q;
    rrem_d    = rrem_q;
    rbits_d   = rbits_q;
    seg_d     = 1'b0;
    rend_d    = 1'b0;
    eol_d     = 1'b0;
    if (in_valid) begin
      prev_d = mode;
      acc_d  = remainder_subtract;
    end
    unique case (1'b1)
      is_count: begin
        cnt_d   = cnt_inc;
        state_d = S_RUN;
        if (seg_hit) begin
          seg_d     = 1'b1;
          idx_d     = idx_inc;
          cmp_d     = cmp_carry ? CNT_MAX : cmp_add;
          cmp_sat_d = cmp_carry;
        end
        if (is_eol) begin
          rend_d    = 1'b1;
          eol_d     = 1'b1;
          rrem_d    = seg_hit ? '0 : cnt_inc - acc_q;
          rbits_d   = J_length'(j_cur);
          cnt_d     = '0;
          cmp_d     = pow2(seg_hit ? j_inc : j_cur);
          cmp_sat_d = 1'b0;
          acc_d     = '0;
          state_d   = S_IDLE;
        end
      end
      is_close: begin
        rend_d    = 1'b1;
        rrem_d    = cnt_q - acc_q;
        rbits_d   = J_length'(j_cur);
        idx_d     = idx_dec;
        cnt_d     = '0;
        cmp_d     = pow2(j_dec);
        cmp_sat_d = 1'b0;
        acc_d     = '0;
        state_d   = S_IDLE;
      end
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmp_q     <= runcount_length'(1);
      cmp_sat_q <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      prev_q    <= '0;
      rrem_q    <= '0;
      rbits_q   <= '0;
      seg_q     <= 1'b0;
      rend_q    <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      cmp_sat_q <= cmp_sat_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      prev_q    <= prev_d;
      rrem_q    <= rrem_d;
      rbits_q   <= rbits_d;
      seg_q     <= seg_d;
      rend_q    <= rend_d;
      eol_q     <= eol_d;
    end
  end

  assign previous_mode            = prev_q;
  assign run_counter              = cnt_q;
  assign run_counter_compare      = cmp_q;
  assign remainder_subtract_accum = acc_q;
  assign run_index                = idx_q;
  assign J                        = J_length'(j_cur);
  assign seg_done                 = seg_q;
  assign run_end                  = rend_q;
  assign run_remainder            = rrem_q;
  assign remainder_bits           = rbits_q;
  assign eol_flush                = eol_q;

endmodule

// File: tb/tb_run_index_tracker.sv
// tb_run_index_tracker: scoreboard bench
// random and directed run streams vs a run-level model
module tb_run_index_tracker;

  localparam int MAXC = 65535;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] remainder_subtract;
  logic [1:0]  previous_mode;
  logic [15:0] run_counter;
  logic [15:0] run_counter_compare;
  logic [15:0] remainder_subtract_accum;
  logic [4:0]  run_index;
  logic [3:0]  J;
  logic        seg_done;
  logic        run_end;
  logic [15:0] run_remainder;
  logic [3:0]  remainder_bits;
  logic        eol_flush;

  run_index_tracker dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .mode                     (mode),
    .remainder_subtract       (remainder_subtract),
    .previous_mode            (previous_mode),
    .run_counter              (run_counter),
    .run_counter_compare      (run_counter_compare),
    .remainder_subtract_accum (remainder_subtract_accum),
    .run_index                (run_index),
    .J                        (J),
    .seg_done                 (seg_done),
    .run_end                  (run_end),
    .run_remainder            (run_remainder),
    .remainder_bits           (remainder_bits),
    .eol_flush                (eol_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int prev, cnt, cmp, acc, idx, j;
    int seg, rend, rrem, rbits, eol;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int JT [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,
                  3,3,3,3,4,4,5,5,6,6,7,7,
                  8,9,10,11,12,13,14,15};

  // run-level model state
  bit     m_open;
  int     m_cnt, m_idx, m_acc, m_prev;
  int     m_rrem, m_rbits, m_base;
  longint m_thr;
  int     m_seg, m_rend, m_eol;

  task automatic chk(input string name,
                     input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endtask

  function automatic int clampc(input longint v);
    return (v > MAXC) ? MAXC : int'(v);
  endfunction

  task automatic model_reset();
    m_open = 0; m_cnt = 0; m_idx = 0; m_acc = 0;
    m_prev = 0; m_rrem = 0; m_rbits = 0;
    m_base = 0; m_thr = 1;
    m_seg = 0; m_rend = 0; m_eol = 0;
  endtask

  task automatic model_close();
    m_cnt  = 0;
    m_thr  = longint'(1) << JT[m_idx];
    m_base = 0;
    m_open = 0;
    m_acc  = 0;
  endtask

  task automatic model_px(input int md, input int rs);
    int jf;
    bit hit;
    if (md == 1 || md == 3) begin
      jf    = JT[m_idx];
      m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      hit   = (longint'(m_cnt) == m_thr);
      if (hit) begin
        m_seg  = 1;
        m_base = m_cnt;
        m_idx  = (m_idx < 31) ? m_idx + 1 : 31;
        m_thr  = m_thr + (longint'(1) << JT[m_idx]);
      end
      m_open = 1;
      if (md == 3) begin
        m_rend  = 1;
        m_eol   = 1;
        m_rrem  = hit ? 0 : ((m_cnt - m_acc) & MAXC);
        m_rbits = jf;
        model_close();
      end else begin
        m_acc = rs;
      end
    end else if (md == 2 && m_open) begin
      m_rend  = 1;
      m_rrem  = (m_cnt - m_acc) & MAXC;
      m_rbits = JT[m_idx];
      m_idx   = (m_idx > 0) ? m_idx - 1 : 0;
      model_close();
    end else begin
      m_acc = rs;
    end
    m_prev = md;
  endtask

  task automatic push_exp();
    exp_t e;
    e.prev = m_prev; e.cnt = m_cnt;
    e.cmp = clampc(m_thr); e.acc = m_acc;
    e.idx = m_idx; e.j = JT[m_idx];
    e.seg = m_seg; e.rend = m_rend;
    e.rrem = m_rrem; e.rbits = m_rbits;
    e.eol = m_eol;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input int md,
                      input int rs);
    @(negedge clk);
    in_valid = v;
    mode = 2'(md);
    remainder_subtract = 16'(rs);
    m_seg = 0; m_rend = 0; m_eol = 0;
    if (v) model_px(md, rs);
    push_exp();
  endtask

  // downstream returns the completed-segment total
  task automatic px(input int md);
    step(1'b1, md, m_base);
  endtask

  task automatic gap();
    step(1'b0, int'($urandom_range(0, 3)),
         int'($urandom_range(0, MAXC)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    reset = 1'b1;
    push_exp();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // monitor: compare registered outputs each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("previous_mode", previous_mode, e.prev);
        chk("run_counter", run_counter, e.cnt);
        chk("run_counter_compare",
            run_counter_compare, e.cmp);
        chk("accum", remainder_subtract_accum, e.acc);
        chk("run_index", run_index, e.idx);
        chk("J", J, e.j);
        chk("seg_done", seg_done, e.seg);
        chk("run_end", run_end, e.rend);
        chk("run_remainder", run_remainder, e.rrem);
        chk("remainder_bits", remainder_bits, e.rbits);
        chk("eol_flush", eol_flush, e.eol);
      end
    end
  end

  initial begin
    int r;
    int md;
    reset = 1'b0;
    in_valid = 1'b0;
    mode = '0;
    remainder_subtract = '0;
    model_reset();
    do_reset();

    // four run pixels from index 0
    repeat (4) px(1);
    settle();
    chk("t1_index", run_index, 4);
    chk("t1_J", J, 1);
    chk("t1_compare", run_counter_compare, 6);

    // run of 3 more then interruption
    repeat (3) px(1);
    px(2);
    settle();
    chk("t2_run_end", run_end, 1);
    chk("t2_remainder", run_remainder, 1);
    chk("t2_bits", remainder_bits, 1);
    chk("t2_index", run_index, 4);

    // end of line exactly on a threshold
    px(1);
    px(3);
    settle();
    chk("t3_seg", seg_done, 1);
    chk("t3_eol", eol_flush, 1);
    chk("t3_remainder", run_remainder, 0);

    // reset in the middle of a run at count 7
    repeat (7) px(1);
    do_reset();
    settle();
    chk("t4_counter", run_counter, 0);
    chk("t4_index", run_index, 0);
    chk("t4_compare", run_counter_compare, 1);
    repeat (3) px(1);

    // random streams with gaps
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        gap();
      end else begin
        r = int'($urandom_range(0, 99));
        if (m_open)
          md = (r < 75) ? 1 : (r < 88) ? 2 : 3;
        else
          md = int'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0)
          step(1'b1, md,
               int'($urandom_range(0, MAXC)));
        else
          px(md);
      end
    end

    // long run to index 31 and counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) px(1);
    settle();
    chk("t5_index", run_index, 31);
    chk("t5_J", J, 15);
    chk("t5_counter", run_counter, MAXC);
    chk("t5_compare", run_counter_compare, MAXC);
    px(3);
    repeat (20) px(1);
    px(2);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
